// File: rtl/clk_ctrl_pkg.sv
// Shared types for the slow-clock run/halt/step controller: controller states
// and the command opcodes seen on CmdOp.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_RUN    = 2'd0,
    OP_HALT   = 2'd1,
    OP_STEP   = 2'd2,
    OP_SETDIV = 2'd3
  } cmd_op_e;

endpackage : clk_ctrl_pkg

// File: rtl/clk_tick_counter.sv
// Programmable divide counter: owns the running count, the active divisor and a
// one-deep pending divisor that is only swapped in at terminal count.
module clk_tick_counter #(
  parameter int          CNT_W     = 26,
  parameter int unsigned DIV_RESET = 9
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             div_wr,
  input  logic             pend_wr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             tc
);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] div_reg_q, div_reg_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;

  assign tc = enable && (div_cnt_q == div_reg_q);

  always_comb begin
    div_cnt_d    = div_cnt_q;
    div_reg_d    = div_reg_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;

    if (clear) begin
      div_cnt_d = '0;
    end else if (enable) begin
      div_cnt_d = tc ? '0 : div_cnt_q + CNT_W'(1);
    end

    // Divisor only changes on a period boundary, so the count never overshoots.
    if (tc && pend_valid_q) begin
      div_reg_d    = pend_div_q;
      pend_valid_d = 1'b0;
    end

    // A direct write while stopped supersedes any stale pending value.
    if (div_wr) begin
      div_reg_d    = wr_data;
      pend_valid_d = 1'b0;
    end

    // Ordered last: a write coinciding with tc queues behind the value just applied.
    if (pend_wr) begin
      pend_div_d   = wr_data;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      div_cnt_q    <= '0;
      div_reg_q    <= CNT_W'(DIV_RESET);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      div_reg_q    <= div_reg_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule : clk_tick_counter

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step sequencer for the core's slow clock: accepts commands,
// drives the tick counter and produces registered TickEn/ClkOut/StepDone.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int          CNT_W     = 26,
  parameter int unsigned DIV_RESET = 9
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic [CNT_W-1:0] CmdData,
  output logic             TickEn,
  output logic             ClkOut,
  output logic             Running,
  output logic             StepDone
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             tick_en_q, tick_en_d;
  logic             clk_out_q, clk_out_d;
  logic             step_done_q, step_done_d;

  cmd_op_e          op;
  logic             cmd_fire;
  logic             stop_cmd;
  logic             cnt_enable;
  logic             cnt_clear;
  logic             div_wr;
  logic             pend_wr;
  logic             tc;
  logic [CNT_W-1:0] step_load;

  assign op        = cmd_op_e'(CmdOp);
  assign CmdReady  = (state_q != ST_STEP);
  assign cmd_fire  = CmdValid && CmdReady;
  assign step_load = (CmdData == '0) ? CNT_W'(1) : CmdData;

  // HALT and STEP restart the period, so a coincident terminal count is dropped.
  assign stop_cmd   = cmd_fire && ((op == OP_HALT) || (op == OP_STEP));
  assign cnt_enable = (state_q != ST_HALT) && !stop_cmd;
  assign cnt_clear  = (state_q == ST_HALT) || stop_cmd;
  assign div_wr     = cmd_fire && (op == OP_SETDIV) && (state_q == ST_HALT);
  assign pend_wr    = cmd_fire && (op == OP_SETDIV) && (state_q == ST_RUN);

  clk_tick_counter #(
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) u_tick_counter (
    .Clk     (Clk),
    .Rst     (Rst),
    .enable  (cnt_enable),
    .clear   (cnt_clear),
    .div_wr  (div_wr),
    .pend_wr (pend_wr),
    .wr_data (CmdData),
    .tc      (tc)
  );

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    tick_en_d   = 1'b0;
    step_done_d = 1'b0;
    clk_out_d   = clk_out_q;

    case (state_q)
      ST_HALT: begin
        clk_out_d = 1'b0;
        if (cmd_fire && (op == OP_RUN)) begin
          state_d = ST_RUN;
        end else if (cmd_fire && (op == OP_STEP)) begin
          state_d    = ST_STEP;
          step_cnt_d = step_load;
        end
      end

      ST_RUN: begin
        if (cmd_fire && (op == OP_HALT)) begin
          state_d   = ST_HALT;
          clk_out_d = 1'b0;
        end else if (cmd_fire && (op == OP_STEP)) begin
          state_d    = ST_STEP;
          step_cnt_d = step_load;
        end else if (tc) begin
          tick_en_d = 1'b1;
          clk_out_d = ~clk_out_q;
        end
      end

      ST_STEP: begin
        if (tc) begin
          tick_en_d = 1'b1;
          if (step_cnt_q == CNT_W'(1)) begin
            step_done_d = 1'b1;
            clk_out_d   = 1'b0;
            step_cnt_d  = '0;
            state_d     = ST_HALT;
          end else begin
            step_cnt_d = step_cnt_q - CNT_W'(1);
            clk_out_d  = ~clk_out_q;
          end
        end
      end

      default: begin
        state_d   = ST_HALT;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_HALT;
      step_cnt_q  <= '0;
      tick_en_q   <= 1'b0;
      clk_out_q   <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      tick_en_q   <= tick_en_d;
      clk_out_q   <= clk_out_d;
      step_done_q <= step_done_d;
    end
  end

  assign TickEn   = tick_en_q;
  assign ClkOut   = clk_out_q;
  assign StepDone = step_done_q;
  assign Running  = (state_q != ST_HALT);

endmodule : clk_step_ctrl
